// File: rtl/dpe_rx_ingress.sv
// AXIS ingress stage in front of the DPE: classifies each frame on its first two
// beats, stamps per-frame tuser sideband and truncates oversize frames.
module dpe_rx_ingress #(
    parameter logic [2:0]  PORT_ID   = 3'd0,
    parameter logic [2:0]  WG_DST    = 3'd4,
    parameter logic [2:0]  CPU_PORT  = 3'd4,
    parameter int unsigned MAX_BEATS = 96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] s_tdata,
    input  logic [15:0]  s_tkeep,
    input  logic         s_tvalid,
    input  logic         s_tlast,
    output logic         s_tready,
    output logic [127:0] m_tdata,
    output logic [15:0]  m_tkeep,
    output logic         m_tvalid,
    output logic         m_tlast,
    input  logic         m_tready,
    output logic         m_tuser_bypass_all,
    output logic [3:0]   m_tuser_bypass_stage,
    output logic [2:0]   m_tuser_src,
    output logic [2:0]   m_tuser_dst,
    output logic [15:0]  frame_cnt,
    output logic [15:0]  byp_cnt,
    output logic [15:0]  trunc_cnt
);
    localparam int unsigned   CW      = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    typedef enum logic [2:0] {IDLE, HOLD, STREAM, FLUSH, DISCARD} state_t;
    state_t state_q, state_d;

    logic          rdy_en_q;
    logic [127:0]  h_data_q, h_data_d;
    logic [15:0]   h_keep_q, h_keep_d;
    logic          h_last_q, h_last_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          byp_q, byp_d;
    logic [2:0]    dst_q, dst_d;
    logic          disc_q, disc_d;
    logic [127:0]  o_data_q, o_data_d;
    logic [15:0]   o_keep_q, o_keep_d;
    logic          o_valid_q, o_valid_d;
    logic          o_last_q, o_last_d;
    logic          o_byp_q, o_byp_d;
    logic [2:0]    o_src_q, o_src_d;
    logic [2:0]    o_dst_q, o_dst_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   byp_cnt_q, byp_cnt_d;
    logic [15:0]   trunc_cnt_q, trunc_cnt_d;
    logic          o_free, acc, wg_hit, trunc_hit, o_load;

    assign o_free    = !o_valid_q || m_tready;
    assign acc       = s_tvalid && s_tready;
    assign cnt_inc   = cnt_q + CW'(1);
    assign trunc_hit = !s_tlast && (cnt_inc == MAX_CNT);
    // H holds beat0 while beat1 is on the input: ethertype/IHL from beat0, protocol from beat1
    assign wg_hit = (h_data_q[103:96] == 8'h08) && (h_data_q[111:104] == 8'h00) &&
                    (h_data_q[119:112] == 8'h45) && (s_tdata[63:56] == 8'h11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:         if (acc) state_d = s_tlast ? FLUSH : HOLD;
            HOLD, STREAM: if (acc) state_d = (s_tlast || trunc_hit) ? FLUSH : STREAM;
            FLUSH:        if (o_free) state_d = disc_q ? DISCARD : IDLE;
            DISCARD:      if (acc && s_tlast) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        s_tready = 1'b0;
        unique case (state_q)
            IDLE, DISCARD: s_tready = rdy_en_q;
            HOLD, STREAM:  s_tready = o_free;
            default:       s_tready = 1'b0;
        endcase
    end

    always_comb begin
        h_data_d    = h_data_q;
        h_keep_d    = h_keep_q;
        h_last_d    = h_last_q;
        cnt_d       = cnt_q;
        byp_d       = byp_q;
        dst_d       = dst_q;
        disc_d      = disc_q;
        o_data_d    = o_data_q;
        o_keep_d    = o_keep_q;
        o_valid_d   = o_valid_q && !m_tready;
        o_last_d    = o_last_q;
        o_byp_d     = o_byp_q;
        o_src_d     = o_src_q;
        o_dst_d     = o_dst_q;
        frame_cnt_d = frame_cnt_q;
        byp_cnt_d   = byp_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        o_load      = 1'b0;
        unique case (state_q)
            IDLE: if (acc) begin
                h_data_d = s_tdata;
                h_keep_d = s_tkeep;
                h_last_d = s_tlast;
                cnt_d    = CW'(1);
                disc_d   = 1'b0;
                byp_d    = 1'b1;
                dst_d    = CPU_PORT;
            end
            HOLD, STREAM: if (acc) begin
                if (state_q == HOLD) begin
                    byp_d = !wg_hit;
                    dst_d = wg_hit ? WG_DST : CPU_PORT;
                end
                o_load   = 1'b1;
                o_last_d = 1'b0;
                h_data_d = s_tdata;
                h_keep_d = s_tkeep;
                h_last_d = s_tlast || trunc_hit;
                cnt_d    = cnt_inc;
                if (trunc_hit) begin
                    trunc_cnt_d = trunc_cnt_q + 16'd1;
                    disc_d      = 1'b1;
                end
            end
            FLUSH: if (o_free) begin
                o_load      = 1'b1;
                o_last_d    = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (byp_q) byp_cnt_d = byp_cnt_q + 16'd1;
            end
            default: ;
        endcase
        // tuser taken from the _d values so the first output beat already carries the verdict
        if (o_load) begin
            o_valid_d = 1'b1;
            o_data_d  = h_data_q;
            o_keep_d  = h_keep_q;
            o_byp_d   = byp_d;
            o_dst_d   = dst_d;
            o_src_d   = PORT_ID;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            h_data_q    <= '0;
            h_keep_q    <= '0;
            h_last_q    <= 1'b0;
            cnt_q       <= '0;
            byp_q       <= 1'b1;
            dst_q       <= '0;
            disc_q      <= 1'b0;
            o_data_q    <= '0;
            o_keep_q    <= '0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
            o_byp_q     <= 1'b0;
            o_src_q     <= '0;
            o_dst_q     <= '0;
            frame_cnt_q <= '0;
            byp_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            rdy_en_q    <= 1'b1;
            h_data_q    <= h_data_d;
            h_keep_q    <= h_keep_d;
            h_last_q    <= h_last_d;
            cnt_q       <= cnt_d;
            byp_q       <= byp_d;
            dst_q       <= dst_d;
            disc_q      <= disc_d;
            o_data_q    <= o_data_d;
            o_keep_q    <= o_keep_d;
            o_valid_q   <= o_valid_d;
            o_last_q    <= o_last_d;
            o_byp_q     <= o_byp_d;
            o_src_q     <= o_src_d;
            o_dst_q     <= o_dst_d;
            frame_cnt_q <= frame_cnt_d;
            byp_cnt_q   <= byp_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign m_tdata              = o_data_q;
    assign m_tkeep              = o_keep_q;
    assign m_tvalid             = o_valid_q;
    assign m_tlast              = o_last_q;
    assign m_tuser_bypass_all   = o_byp_q;
    assign m_tuser_bypass_stage = 4'h0;
    assign m_tuser_src          = o_src_q;
    assign m_tuser_dst          = o_dst_q;
    assign frame_cnt            = frame_cnt_q;
    assign byp_cnt              = byp_cnt_q;
    assign trunc_cnt            = trunc_cnt_q;
endmodule

// File: tb/tb_dpe_rx_ingress.sv
// Bench for dpe_rx_ingress: frame-level reference model fed by randomized frames,
// one compare process on the output handshake, plus literal pins.
module tb_dpe_rx_ingress;
    localparam int unsigned MAXB = 96;
    localparam logic [2:0]  WGD  = 3'd4;
    localparam logic [2:0]  CPUP = 3'd6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic         s_tvalid, s_tlast, s_tready;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tvalid, m_tlast, m_tready;
    logic         m_tuser_bypass_all;
    logic [3:0]   m_tuser_bypass_stage;
    logic [2:0]   m_tuser_src, m_tuser_dst;
    logic [15:0]  frame_cnt, byp_cnt, trunc_cnt;

    always #4 clk = ~clk;

    dpe_rx_ingress #(.PORT_ID(3'd0), .WG_DST(WGD), .CPU_PORT(CPUP), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .m_tuser_bypass_all(m_tuser_bypass_all), .m_tuser_bypass_stage(m_tuser_bypass_stage),
        .m_tuser_src(m_tuser_src), .m_tuser_dst(m_tuser_dst),
        .frame_cnt(frame_cnt), .byp_cnt(byp_cnt), .trunc_cnt(trunc_cnt)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic         b;
        logic [2:0]   dst;
    } beat_t;

    beat_t        exp_q[$];
    logic [127:0] fr_data[$];
    logic [15:0]  fr_keep[$];
    int unsigned  n_chk = 0, n_pass = 0;
    int unsigned  m_frames = 0, m_byp = 0, m_trunc = 0;
    bit           chk_en = 0;
    int unsigned  rmode = 0, pidx = 0;
    logic [4:0]   pat = 5'b01101;   // ready sequence 1,0,1,1,0 read from bit 0 upward

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic build_frame(input int unsigned len, input int unsigned kind, input logic [15:0] last_keep);
        logic [127:0] b;
        fr_data.delete();
        fr_keep.delete();
        for (int unsigned i = 0; i < len; i++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0 && kind != 0) begin
                b[103:96]  = 8'h08;
                b[111:104] = 8'h00;
                b[119:112] = (kind == 2) ? 8'h05 : 8'h45;
            end
            if (i == 1 && kind != 0) b[63:56] = (kind == 3) ? 8'h06 : 8'h11;
            fr_data.push_back(b);
            fr_keep.push_back((i == len - 1) ? last_keep : 16'hFFFF);
        end
    endtask

    // Frame-level reference: classify from raw bytes, cut at MAXB beats.
    task automatic model_frame();
        int unsigned  len = fr_data.size();
        int unsigned  n   = (len > MAXB) ? MAXB : len;
        logic [127:0] b0, b1;
        bit           wg;
        beat_t        e;
        b0 = fr_data[0];
        b1 = (len > 1) ? fr_data[1] : '0;
        wg = (len > 1) && b0[103:96] == 8'h08 && b0[111:104] == 8'h00 &&
             b0[119:112] == 8'h45 && b1[63:56] == 8'h11;
        for (int unsigned i = 0; i < n; i++) begin
            e.d   = fr_data[i];
            e.k   = fr_keep[i];
            e.l   = (i == n - 1);
            e.b   = !wg;
            e.dst = wg ? WGD : CPUP;
            exp_q.push_back(e);
        end
        m_frames++;
        if (!wg) m_byp++;
        if (len > MAXB) m_trunc++;
    endtask

    task automatic drive_beat(input int unsigned i);
        s_tvalid = 1'b1;
        s_tdata  = fr_data[i];
        s_tkeep  = fr_keep[i];
        s_tlast  = (i == fr_data.size() - 1);
    endtask

    task automatic wait_accept();
        int unsigned cyc = 0;
        bit          done = 0;
        while (!done) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else if (++cyc > 2000) begin
                n_chk++;
                $display("FAIL accept_timeout: s_tready low for %0d cycles, required an accept", cyc);
                done = 1;
            end
        end
    endtask

    task automatic send_frame(input int unsigned gap_pct);
        for (int unsigned i = 0; i < fr_data.size(); i++) begin
            while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            drive_beat(i);
            wait_accept();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic frame(input int unsigned len, input int unsigned kind, input logic [15:0] lk,
                         input int unsigned gap_pct);
        build_frame(len, kind, lk);
        model_frame();
        send_frame(gap_pct);
    endtask

    task automatic drain();
        int unsigned cyc = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d beats still owed, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, " frame_cnt"}, 128'(frame_cnt), 128'(m_frames[15:0]));
        chk({tag, " byp_cnt"},   128'(byp_cnt),   128'(m_byp[15:0]));
        chk({tag, " trunc_cnt"}, 128'(trunc_cnt), 128'(m_trunc[15:0]));
    endtask

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: m_tready = 1'b1;
            1: begin
                m_tready = pat[pidx];
                pidx     = (pidx + 1) % 5;
            end
            default: m_tready = ($urandom_range(99) < 65);
        endcase
    end

    logic [149:0] st_snap;
    bit           stall_pend = 0;
    beat_t        ce;
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (stall_pend) begin
                n_chk++;
                if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser_bypass_all, m_tuser_dst} === st_snap)
                    n_pass++;
                else
                    $display("FAIL stall_hold: got %h required %h",
                             {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser_bypass_all, m_tuser_dst}, st_snap);
            end
            stall_pend = 0;
            if (m_tvalid && !m_tready) begin
                stall_pend = 1;
                st_snap    = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser_bypass_all, m_tuser_dst};
            end
            if (m_tvalid && m_tready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL out_beat: got extra beat d=%h, required no beat", m_tdata);
                end else begin
                    ce = exp_q.pop_front();
                    if (m_tdata === ce.d && m_tkeep === ce.k && m_tlast === ce.l &&
                        m_tuser_bypass_all === ce.b && m_tuser_dst === ce.dst &&
                        m_tuser_src === 3'd0 && m_tuser_bypass_stage === 4'h0)
                        n_pass++;
                    else
                        $display("FAIL out_beat: got d=%h k=%h l=%b b=%b dst=%0d src=%0d stg=%0h required d=%h k=%h l=%b b=%b dst=%0d src=0 stg=0",
                                 m_tdata, m_tkeep, m_tlast, m_tuser_bypass_all, m_tuser_dst, m_tuser_src,
                                 m_tuser_bypass_stage, ce.d, ce.k, ce.l, ce.b, ce.dst);
                end
            end
        end else begin
            stall_pend = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        m_tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst m_tlast", 128'(m_tlast), 128'(0));
        chk("rst m_tdata", m_tdata, 128'(0));
        chk("rst m_tuser", 128'({m_tuser_bypass_all, m_tuser_src, m_tuser_dst, m_tkeep}), 128'(0));
        chk("rst s_tready", 128'(s_tready), 128'(0));
        chk("rst counters", 128'({frame_cnt, byp_cnt, trunc_cnt}), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("release s_tready before clk", 128'(s_tready), 128'(0));
        @(posedge clk);
        #1;
        chk("release s_tready after clk", 128'(s_tready), 128'(1));
        chk_en = 1;

        // 1: 11-beat IPv4/UDP frame, short last beat
        rmode = 0;
        build_frame(11, 1, 16'h03FF);
        model_frame();
        chk("pin t1 beats", 128'(exp_q.size()), 128'(11));
        chk("pin t1 bypass", 128'(exp_q[0].b), 128'(0));
        chk("pin t1 last", 128'({exp_q[10].l, exp_q[10].k}), 128'(17'h103FF));
        send_frame(0);
        drain();
        chk("t1 frame_cnt", 128'(frame_cnt), 128'(1));
        chk("t1 byp_cnt", 128'(byp_cnt), 128'(0));

        // 2: same shape with IHL byte broken -> bypass
        frame(11, 2, 16'h03FF, 0);
        drain();
        chk("t2 byp_cnt", 128'(byp_cnt), 128'(1));
        chk("t2 frame_cnt", 128'(frame_cnt), 128'(2));

        // 3: single-beat frame carrying a WG-looking header still bypasses
        build_frame(1, 1, 16'hFFFF);
        model_frame();
        chk("pin t3 bypass", 128'({exp_q[0].b, exp_q[0].l}), 128'(2'b11));
        send_frame(0);
        drain();
        chk("t3 byp_cnt", 128'(byp_cnt), 128'(2));
        check_counters("t3");

        // 4: back-to-back frames under a fixed ready pattern
        rmode = 1;
        pidx  = 0;
        frame(5, 1, 16'h00FF, 0);
        frame(1, 0, 16'h0001, 0);
        frame(7, 3, 16'h7FFF, 0);
        frame(3, 1, 16'hFFFF, 0);
        drain();
        check_counters("t4");

        // 5: oversize truncation, exact-limit and limit+1 frames
        rmode = 2;
        build_frame(100, 1, 16'hFFFF);
        model_frame();
        chk("pin t5 beats", 128'(exp_q.size()), 128'(96));
        send_frame(0);
        frame(11, 1, 16'h03FF, 0);
        drain();
        chk("t5 trunc_cnt", 128'(trunc_cnt), 128'(1));
        frame(96, 0, 16'h0FFF, 10);
        frame(97, 1, 16'h0003, 10);
        drain();
        chk("t5 trunc_cnt after 97", 128'(trunc_cnt), 128'(2));
        check_counters("t5");

        // 6: reset pulse during beat 5, then a clean frame
        chk_en = 0;
        build_frame(11, 1, 16'h03FF);
        for (int unsigned i = 0; i < 4; i++) begin
            drive_beat(i);
            wait_accept();
        end
        drive_beat(4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6 m_tvalid in reset", 128'(m_tvalid), 128'(0));
        chk("t6 counters in reset", 128'({frame_cnt, byp_cnt, trunc_cnt}), 128'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        exp_q.delete();
        m_frames = 0;
        m_byp    = 0;
        m_trunc  = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        frame(11, 1, 16'h03FF, 0);
        drain();
        chk("t6 frame_cnt", 128'(frame_cnt), 128'(1));
        chk("t6 byp_cnt", 128'(byp_cnt), 128'(0));
        check_counters("t6");

        // 7: randomized traffic
        rmode = 2;
        for (int unsigned f = 0; f < 30; f++) begin
            frame($urandom_range(24, 1), $urandom_range(3), 16'hFFFF >> $urandom_range(15), 25);
        end
        drain();
        check_counters("t7");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
